fifo_byte_serializer: RTL

- Drain stage directly downstream of the team's 4-deep x 32-bit FIFO.
- Consumes the FIFO's show-ahead output: data_out is valid whenever fifo_empty is low.
- Pops one word at a time and emits it LSB-byte-first on an 8-bit valid/ready stream.
- Sustains one byte per cycle with zero bubbles between consecutive words.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_byte_serializer.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO drain path.
package fifo_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    localparam int FIFO_WIDTH     = 32;
    localparam int BYTE_WIDTH     = 8;
    localparam int BYTES_PER_WORD = FIFO_WIDTH / BYTE_WIDTH;

    // Number of output beats needed to carry one FIFO word.
    function automatic int bytes_per_word(input int width, input int byte_w);
        return width / byte_w;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drains a show-ahead FIFO one word at a time and streams each word out
// LSB-byte-first on a valid/ready byte interface, with no bubble between
// consecutive words.
module fifo_byte_serializer
    import fifo_pkg::*;
#(
    parameter int fifo_width = FIFO_WIDTH,
    parameter int byte_width = BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [fifo_width-1:0] fifo_data,
    output logic                  pop,
    output logic [byte_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           byte_count
);

    localparam int N     = bytes_per_word(fifo_width, byte_width);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // A word must split into a whole number of output beats.
    generate
        if (fifo_width % byte_width != 0) begin : g_bad_width
            $error("fifo_width must be an integer multiple of byte_width");
        end
    endgenerate

    ser_state_t            state, state_next;
    logic [fifo_width-1:0] shreg, shreg_next;
    logic [IDX_W-1:0]      byte_idx, byte_idx_next;
    logic                  can_pop;
    logic                  handshake;

    assign can_pop   = enable & ~fifo_empty & ~reset;
    assign handshake = out_valid & out_ready;

    // Next-state, datapath and output decode; the final beat of a word may
    // reload the shift register directly so the stream never idles.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        byte_idx_next = byte_idx;
        pop           = 1'b0;
        out_valid     = 1'b0;
        out_data      = '0;
        out_last      = 1'b0;
        case (state)
            IDLE: begin
                pop = can_pop;
                if (can_pop) begin
                    shreg_next    = fifo_data;
                    byte_idx_next = '0;
                    state_next    = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = shreg[byte_width-1:0];
                out_last  = (byte_idx == LAST_IDX);
                if (out_ready) begin
                    if (byte_idx != LAST_IDX) begin
                        shreg_next    = shreg >> byte_width;
                        byte_idx_next = byte_idx + 1'b1;
                    end else if (can_pop) begin
                        pop           = 1'b1;
                        shreg_next    = fifo_data;
                        byte_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, shift register and byte index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            byte_idx <= byte_idx_next;
        end
    end

    // Free-running count of accepted bytes; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count <= '0;
        end else if (handshake) begin
            byte_count <= byte_count + 16'd1;
        end
    end

endmodule
